serial_sub: RTL and testbench

Bit-serial two's-complement subtractor for the ALU: computes `a - b` one bit per clock, LSB first, using a single borrow flop in place of the ripple chain of the combinational adder. It is the inverse counterpart of the 16-bit `add` block and is for area-constrained datapaths where a multi-cycle subtract is acceptable. A start/busy/done handshake connects it to the control unit.

---
 rtl/serial_sub.sv | 140 ++++++++++++++
 tb/tb_serial_sub.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_sub.sv
// serial_sub: bit-serial two's-complement subtractor, diff = a - b.
// One bit per clock, LSB first, with a single borrow flop replacing the
// ripple chain. Handshake to the control unit is start / busy / done.
//
// Handshake (one rule for the whole block):
//   start is sampled on a rising edge only while the FSM is in IDLE or DONE.
//   That edge latches a and b, and busy goes high for exactly WIDTH cycles.
//   The edge after the last bit raises done for one cycle, with busy low.
//   diff / borrow / overflow are holding registers. They change only when
//   the FSM enters DONE, so the previous result stays readable during RUN.
module serial_sub #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;      // minuend, shifted right one bit per RUN cycle
  logic [WIDTH-1:0] b_sh;      // subtrahend, shifted alongside a_sh
  logic [WIDTH-1:0] res_sh;    // result bits enter at the MSB, LSB first
  logic             br;        // borrow carried into the current bit
  logic [CW-1:0]    cnt;       // index of the bit being processed
  logic             sign_a;    // operand sign bits kept for the overflow rule
  logic             sign_b;

  logic             bit_a;
  logic             bit_b;
  logic             bit_d;
  logic             br_next;
  logic [WIDTH-1:0] res_next;

  // Full-subtractor cell for the current bit pair.
  always_comb begin
    bit_a    = a_sh[0];
    bit_b    = b_sh[0];
    bit_d    = bit_a ^ bit_b ^ br;
    br_next  = (~bit_a & bit_b) | (~(bit_a ^ bit_b) & br);
    res_next = {bit_d, res_sh[WIDTH-1:1]};
  end

  // Control FSM, datapath shift registers and registered result outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      a_sh     <= '0;
      b_sh     <= '0;
      res_sh   <= '0;
      br       <= 1'b0;
      cnt      <= '0;
      sign_a   <= 1'b0;
      sign_b   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      diff     <= '0;
      borrow   <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          busy <= 1'b0;
          done <= 1'b0;
          if (start) begin
            a_sh   <= a;
            b_sh   <= b;
            res_sh <= '0;
            br     <= 1'b0;
            cnt    <= '0;
            sign_a <= a[WIDTH-1];
            sign_b <= b[WIDTH-1];
            busy   <= 1'b1;
            state  <= RUN;
          end
        end

        RUN: begin
          // start and the a/b pins are deliberately not looked at here.
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          res_sh <= res_next;
          br     <= br_next;
          cnt    <= cnt + CW'(1);
          if (cnt == LAST_BIT) begin
            // Last bit: publish the result in the same edge that enters DONE.
            cnt      <= '0;
            diff     <= res_next;
            borrow   <= br_next;
            overflow <= (sign_a ^ sign_b) & (sign_a ^ bit_d);
            busy     <= 1'b0;
            done     <= 1'b1;
            state    <= DONE;
          end
        end

        DONE: begin
          done <= 1'b0;
          if (start) begin
            // Back-to-back: accept the next operation straight from DONE.
            a_sh   <= a;
            b_sh   <= b;
            res_sh <= '0;
            br     <= 1'b0;
            cnt    <= '0;
            sign_a <= a[WIDTH-1];
            sign_b <= b[WIDTH-1];
            busy   <= 1'b1;
            state  <= RUN;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end

        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_sub.sv
// tb_serial_sub: self-checking bench for serial_sub (WIDTH = 16).
// A scoreboard queue holds {overflow, borrow, diff} expected per start;
// a monitor pops and compares on every done pulse.
module tb_serial_sub;

  localparam int W = 16;

  logic         clk;
  logic         reset;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         borrow;
  logic         overflow;

  logic [W+1:0] exp_q[$];

  int tests_run = 0;
  int failed    = 0;

  serial_sub #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .diff     (diff),
    .borrow   (borrow),
    .overflow (overflow)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W-1:0] d;
    logic         br;
    logic         ov;
    d  = x - y;
    br = (x < y);
    ov = (x[W-1] ^ y[W-1]) & (x[W-1] ^ d[W-1]);
    return {ov, br, d};
  endfunction

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [W+1:0] e;
    if (busy && done) begin
      tests_run++;
      failed++;
      $display("FAIL busy_done_overlap: busy=%0b done=%0b, required not both 1", busy, done);
    end
    if (done) begin
      if (exp_q.size() == 0) begin
        tests_run++;
        failed++;
        $display("FAIL unexpected_done: done=1 with no operation outstanding (diff=%0d)", diff);
      end else begin
        e = exp_q.pop_front();
        tests_run++;
        if (diff !== e[W-1:0]) begin
          failed++;
          $display("FAIL sb_diff: got %0d, expected %0d", diff, e[W-1:0]);
        end
        tests_run++;
        if (borrow !== e[W]) begin
          failed++;
          $display("FAIL sb_borrow: got %0b, expected %0b (diff exp %0d)", borrow, e[W], e[W-1:0]);
        end
        tests_run++;
        if (overflow !== e[W+1]) begin
          failed++;
          $display("FAIL sb_overflow: got %0b, expected %0b (diff exp %0d)", overflow, e[W+1], e[W-1:0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Pulse start for one edge with operands x, y; returns at the negedge
  // after the accepting edge (first RUN cycle).
  task automatic do_start(input logic [W-1:0] x, input logic [W-1:0] y);
    @(negedge clk);
    a     = x;
    b     = y;
    start = 1'b1;
    exp_q.push_back(model(x, y));
    @(negedge clk);
    start = 1'b0;
  endtask

  // Wait (bounded) until done is seen at a negedge.
  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (!done && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!done) begin
      tests_run++;
      failed++;
      $display("FAIL done_timeout: no done within %0d cycles", budget);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    repeat (2) @(negedge clk);
    tests_run++;
    if ({busy, done, borrow, overflow} !== 4'b0000) begin
      failed++;
      $display("FAIL reset_flags: busy/done/borrow/ovf=%b, expected 0000", {busy, done, borrow, overflow});
    end
    tests_run++;
    if (diff !== '0) begin
      failed++;
      $display("FAIL reset_diff: got %0d, expected 0", diff);
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    tests_run++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      failed++;
      $display("FAIL idle_after_reset: busy=%0b done=%0b, expected 0 0", busy, done);
    end
  endtask

  task automatic test_basic();
    int n;
    do_start(16'd10, 16'd5);
    n = 0;
    while (!done && n < 40) begin
      if (busy) n++;
      @(negedge clk);
    end
    tests_run++;
    if (n !== W) begin
      failed++;
      $display("FAIL busy_cycles: got %0d, expected %0d", n, W);
    end
    wait_done(5);
  endtask

  task automatic test_borrow_cases();
    do_start(16'd0, 16'd1);
    wait_done(40);
    do_start(16'd65535, 16'd65535);
    wait_done(40);
  endtask

  task automatic test_overflow_cases();
    do_start(16'd32768, 16'd1);
    wait_done(40);
    do_start(16'd32767, 16'd65535);
    wait_done(40);
  endtask

  task automatic test_start_ignored();
    logic [W+1:0] prev;
    int           n;
    int           hold_bad;
    int           extra;
    prev     = model(16'd32767, 16'd65535);
    hold_bad = 0;
    do_start(16'd300, 16'd44);
    n = 0;
    while (!done && n < 40) begin
      if ({overflow, borrow, diff} !== prev) hold_bad++;
      n++;
      if (n >= 3 && n <= 5) begin
        start = 1'b1;
        a     = 16'd7;
        b     = 16'd9;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    tests_run++;
    if (hold_bad !== 0) begin
      failed++;
      $display("FAIL hold_during_run: %0d cycles changed, expected 0 (prev diff %0d)", hold_bad, prev[W-1:0]);
    end
    wait_done(5);
    extra = 0;
    repeat (W + 4) begin
      @(negedge clk);
      if (done) extra++;
    end
    tests_run++;
    if (extra !== 0) begin
      failed++;
      $display("FAIL start_in_run: %0d extra done pulses, expected 0", extra);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    int hold_bad;
    do_start(16'd256, 16'd44);
    wait_done(40);
    a     = 16'd5;
    b     = 16'd5;
    start = 1'b1;
    exp_q.push_back(model(16'd5, 16'd5));
    n        = 0;
    hold_bad = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) start = 1'b0;
      if (!done && diff !== 16'd212) hold_bad++;
    end while (!done && n < 40);
    tests_run++;
    if (n !== W + 1) begin
      failed++;
      $display("FAIL b2b_spacing: got %0d cycles, expected %0d", n, W + 1);
    end
    tests_run++;
    if (hold_bad !== 0) begin
      failed++;
      $display("FAIL b2b_hold: %0d cycles without 212, expected 0", hold_bad);
    end
  endtask

  task automatic test_reset_mid_run();
    int spurious;
    do_start(16'd32767, 16'd65535);
    wait_done(40);
    do_start(16'd1000, 16'd3);
    repeat (7) @(negedge clk);
    #2;
    reset = 1'b1;
    exp_q.delete();
    #1;
    tests_run++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      failed++;
      $display("FAIL async_reset_ctl: busy=%0b done=%0b, expected 0 0", busy, done);
    end
    tests_run++;
    if (diff !== '0) begin
      failed++;
      $display("FAIL async_reset_diff: got %0d, expected 0", diff);
    end
    tests_run++;
    if (borrow !== 1'b0 || overflow !== 1'b0) begin
      failed++;
      $display("FAIL async_reset_flags: borrow=%0b overflow=%0b, expected 0 0", borrow, overflow);
    end
    @(negedge clk);
    reset    = 1'b0;
    spurious = 0;
    repeat (W + 6) begin
      @(negedge clk);
      if (done) spurious++;
    end
    tests_run++;
    if (spurious !== 0) begin
      failed++;
      $display("FAIL done_after_reset: %0d pulses, expected 0", spurious);
    end
    do_start(16'd1, 16'd0);
    wait_done(40);
  endtask

  task automatic test_random();
    logic [W-1:0] x;
    logic [W-1:0] y;
    for (int i = 0; i < 6; i++) begin
      x = W'($urandom_range(0, 65535));
      y = W'($urandom_range(0, 65535));
      do_start(x, y);
      wait_done(40);
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_basic();
    test_borrow_cases();
    test_overflow_cases();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid_run();
    test_random();
    repeat (3) @(negedge clk);
    tests_run++;
    if (exp_q.size() !== 0) begin
      failed++;
      $display("FAIL sb_leftover: %0d results never produced, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("[TB] %0d tests run, %0d failed", tests_run, failed + 1);
    $fatal(1);
  end

endmodule
